// File: rtl/fft_sink_if.sv
// Packet interface between the frame transmitter and the FFT core sink port.
// Ready-latency 0: a beat moves on every clock where sink_valid and sink_ready are both high.
interface fft_sink_if #(
    parameter int OW = 18
) ();
    logic          sink_valid;
    logic          sink_ready;
    logic          sink_startofpacket;
    logic          sink_endofpacket;
    logic [OW-1:0] sink_real;
    logic [OW-1:0] sink_imag;

    modport master (
        output sink_valid, sink_startofpacket, sink_endofpacket, sink_real, sink_imag,
        input  sink_ready
    );

    modport slave (
        input  sink_valid, sink_startofpacket, sink_endofpacket, sink_real, sink_imag,
        output sink_ready
    );
endinterface

// File: rtl/fft_frame_tx.sv
// Ping-pong frame buffer feeding the FFT sink port.
// Audio samples fill one bank while the other is streamed out as an N-point
// complex packet (real = sign-extended sample, imag = 0).
//
// state | meaning
// IDLE  | waiting for the read bank to become full; loads beat 0 when it does
// SEND  | presenting beats of bank rb; releases the bank when eop transfers
module fft_frame_tx #(
    parameter int N  = 256,
    parameter int DW = 16,
    parameter int OW = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] i_sample,
    input  logic                 i_sample_valid,
    fft_sink_if.master           snk,
    output logic                 o_overflow,
    output logic [7:0]           o_drop_cnt,
    output logic [15:0]          o_frame_cnt
);
    localparam int AW = $clog2(N);

    typedef enum logic {IDLE, SEND} state_t;

    logic [DW-1:0]        mem_q [0:2*N-1];
    state_t               state_q, state_d;
    logic [1:0]           full_q, full_d, set_full, clr_full;
    logic                 wb_q, wb_d, rb_q, rb_d;
    logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic                 valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [OW-1:0]        real_q, real_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           drop_q, drop_d;
    logic [15:0]          frame_q, frame_d;
    logic                 wr_en;
    logic signed [DW-1:0] rd_data;
    logic                 load_beat;

    // Write side: store into bank wb unless it is still waiting to be sent.
    always_comb begin
        wr_en    = 1'b0;
        wp_d     = wp_q;
        wb_d     = wb_q;
        ovf_d    = 1'b0;
        drop_d   = drop_q;
        set_full = 2'b00;
        if (i_sample_valid) begin
            if (full_q[wb_q]) begin
                ovf_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
                wr_en = 1'b1;
                wp_d  = wp_q + AW'(1);
                if (wp_q == AW'(N - 1)) begin
                    set_full[wb_q] = 1'b1;
                    wb_d           = ~wb_q;
                end
            end
        end
    end

    // Read FSM: next state and the registered beat presented on the sink port.
    always_comb begin
        state_d   = state_q;
        rp_d      = rp_q;
        rb_d      = rb_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        real_d    = real_q;
        frame_d   = frame_q;
        clr_full  = 2'b00;
        load_beat = 1'b0;
        rd_data   = $signed(mem_q[{rb_q, rp_q}]);
        case (state_q)
            IDLE: begin
                if (full_q[rb_q]) begin
                    load_beat = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (valid_q && snk.sink_ready) begin
                    if (eop_q) begin
                        valid_d        = 1'b0;
                        sop_d          = 1'b0;
                        eop_d          = 1'b0;
                        real_d         = '0;
                        clr_full[rb_q] = 1'b1;
                        rb_d           = ~rb_q;
                        frame_d        = frame_q + 16'd1;
                        state_d        = IDLE;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // rp wraps back to 0 after the last beat is loaded, ready for the next frame.
        if (load_beat) begin
            valid_d = 1'b1;
            sop_d   = (rp_q == '0);
            eop_d   = (rp_q == AW'(N - 1));
            real_d  = OW'(rd_data);
            rp_d    = rp_q + AW'(1);
        end
    end

    assign full_d = (full_q & ~clr_full) | set_full;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            full_q  <= 2'b00;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            real_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 8'd0;
            frame_q <= 16'd0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            real_q  <= real_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            frame_q <= frame_d;
        end
    end

    // Sample storage; contents need no reset since the full flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[{wb_q, wp_q}] <= i_sample;
    end

    assign snk.sink_valid         = valid_q;
    assign snk.sink_startofpacket = sop_q;
    assign snk.sink_endofpacket   = eop_q;
    assign snk.sink_real          = real_q;
    assign snk.sink_imag          = '0;
    assign o_overflow             = ovf_q;
    assign o_drop_cnt             = drop_q;
    assign o_frame_cnt            = frame_q;
endmodule

// File: doc/fft_frame_tx.md
Name: fft_frame_tx

Overview:
- Transmitter side of the FFT sink packet interface (sink_valid / sink_startofpacket / sink_endofpacket / sink_real / sink_imag, ready-latency 0).
- Accepts a stream of 16-bit audio samples from the SRAM voice path and buffers them in a two-bank ping-pong store.
- Emits each full bank as one N-point complex packet to the FFT core: real part is the sign-extended sample, imaginary part is 0.
- Sits between the voice-collection path and the FFT core, feeding the packets that fft_calfre later sees on the source side.

Parameters:
N, 256, points per FFT frame (power of two, ≥4)
DW, 16, input sample width (signed)
OW, 18, FFT input width; OW ≥ DW

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_sample  in  DW  signed audio sample
i_sample_valid  in  1  i_sample is valid this cycle
sink_ready  in  1  FFT core can accept a beat
sink_valid  out  1  beat valid
sink_real  out  OW  sign-extended sample
sink_imag  out  OW  always 0
sink_startofpacket  out  1  first beat of a frame
sink_endofpacket  out  1  beat N-1 of a frame
o_overflow  out  1  one-cycle pulse: an input sample was dropped
o_drop_cnt  out  8  dropped-sample count, saturates at 255
o_frame_cnt  out  16  frames fully sent, wraps

Behaviour:
- Reset: one clock with synchronous, active-high rst.
  - Outputs cleared: sink_valid, sink_startofpacket, sink_endofpacket, sink_real, sink_imag, o_overflow, o_drop_cnt, o_frame_cnt all 0.
  - State cleared: both bank-full flags 0, write bank wb=0, read bank rb=0, write/read pointers 0, FSM=IDLE.
  - rst mid-packet aborts the packet; no eop is emitted and buffered data is discarded.
- Write side:
  - Each cycle with i_sample_valid=1 and full[wb]=0, store the sample at buf[wb][wp] and increment wp.
  - On the write at wp=N-1: set full[wb]=1, toggle wb, set wp=0.
  - If i_sample_valid=1 and full[wb]=1, drop the sample, pulse o_overflow the next cycle, and increment o_drop_cnt (saturating).
  - full is sampled at the start of the cycle. A sample arriving in the same cycle the reader clears full[wb] is still dropped.
- Read FSM:
  - IDLE: if full[rb]=1, go to SEND with rp=0. The first beat is registered and appears with sink_valid=1 one cycle later.
  - SEND: sink_real = sign-extend(buf[rb][rp]); sink_startofpacket = (rp==0); sink_endofpacket = (rp==N-1).
  - All sink_* outputs are registered and held stable while sink_valid=1 and sink_ready=0.
  - A beat transfers when sink_valid and sink_ready are both 1. The next beat is presented in the following cycle, so there are no bubbles while ready stays high.
  - When the eop beat transfers: clear full[rb], toggle rb, increment o_frame_cnt, go to IDLE. sink_valid=0 for at least one cycle between packets.
  - Exactly N beats per packet, with sop and eop each asserted once.
- Latency: the last sample of a frame is written in cycle t; sop is valid at t+2 if the reader is idle.
- Simultaneous events:
  - The writer completing bank A and the reader releasing bank B in the same cycle are both honoured.
  - Writing and reading the same address in different banks is always legal. The same bank is never read and written at once, by construction.
- Sign extension: sink_real[OW-1:DW] = i_sample[DW-1].

Test Plan:
- Steady feed, N=256, samples 0..255 with valid every cycle, sink_ready=1 → one packet: sop on the beat with real=0, eop on real=255, imag=0 throughout, o_frame_cnt=1, o_drop_cnt=0.
- Negative samples 16'h8000 and 16'hFFFF → sink_real=18'h38000 and 18'h3FFFF.
- Backpressure: sink_ready toggles 1,0,0,1… during the packet → each beat is held stable while ready=0, no beat is duplicated or lost, 256 transfers occur, and the data order is preserved.
- Overflow: sink_ready=0 while 3×256 samples are fed → 512 are stored, 256 are dropped, o_drop_cnt=255 (saturated), and o_overflow pulses once per dropped sample. After ready=1, two packets emerge carrying samples 0..511.
- Continuous stream of 1750 ramp samples (value = cycle count) with ready=1 → 6 full packets, each with one sop and one eop, each carrying a consecutive ramp and at least one idle cycle between packets; the 214 leftover samples are buffered and not sent.
- rst asserted for one cycle at beat 100 of a packet → next cycle all outputs are 0. A fresh 256-sample feed then yields a clean packet starting with sop.
